// File: rtl/pending_encoder_32to5.sv
// Pending-request encoder: accumulates a 32-bit request vector and serialises
// it into a stream of 5-bit indices, lowest-numbered bit first.
//
// Ports:
//   i_clk     : clock, all state updates on rising edge
//   i_rst     : synchronous active-high reset
//   i_in      : 32-bit request vector, OR-merged into pending when i_load=1
//   i_load    : load strobe for i_in
//   i_e       : encoder enable; gates o_valid and handshakes
//   i_ack     : consumer accepts o_out (honoured only when o_valid=1)
//   o_out     : index of lowest pending bit, 0 when o_valid=0
//   o_valid   : i_e and at least one bit pending
//   o_count   : registered population count of pending bits (0..32)
//   o_overrun : sticky, a load hit a bit that was already pending
//   o_state   : 0=IDLE, 1=ACTIVE
module pending_encoder_32to5 (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_in,
    input  logic        i_load,
    input  logic        i_e,
    input  logic        i_ack,
    output logic [4:0]  o_out,
    output logic        o_valid,
    output logic [5:0]  o_count,
    output logic        o_overrun,
    output logic        o_state
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_p;
    logic [5:0]  r_count;
    logic        r_overrun;

    logic [4:0]  w_idx;
    logic        w_valid;
    logic [4:0]  w_out;
    logic        w_hs;
    logic [31:0] w_clr;
    logic [31:0] w_ld;
    logic [31:0] w_p_next;
    logic        w_ovr_hit;
    logic [5:0]  w_pop;

    // Lowest set bit wins: scan from the top so the last match is the lowest.
    always_comb begin
        w_idx = '0;
        for (int i = 31; i >= 0; i--) begin
            if (r_p[i]) begin
                w_idx = 5'(i);
            end
        end
    end

    assign w_valid = i_e & (|r_p);
    assign w_out   = w_valid ? w_idx : 5'd0;
    assign w_hs    = w_valid & i_ack;
    assign w_clr   = w_hs ? (32'h1 << w_out) : 32'h0;
    assign w_ld    = i_load ? i_in : 32'h0;

    // Load is applied after the clear, so a bit loaded on the same edge it
    // is handshaken stays pending and is not counted as an overrun.
    assign w_p_next  = (r_p & ~w_clr) | w_ld;
    assign w_ovr_hit = |(w_ld & r_p & ~w_clr);

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < 32; i++) begin
            w_pop = w_pop + {5'd0, w_p_next[i]};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_p       <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
            r_state   <= ST_IDLE;
        end else begin
            r_p     <= w_p_next;
            r_count <= w_pop;
            if (w_ovr_hit) begin
                r_overrun <= 1'b1;
            end
            unique case (r_state)
                ST_IDLE: begin
                    if (|w_p_next) begin
                        r_state <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (w_p_next == 32'h0) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_out     = w_out;
    assign o_valid   = w_valid;
    assign o_count   = r_count;
    assign o_overrun = r_overrun;
    assign o_state   = r_state;

endmodule

// File: tb/tb_pending_encoder_32to5.sv
// Directed scoreboard bench for pending_encoder_32to5.
// Expected outputs are queued with each stimulus step and checked after it.
module tb_pending_encoder_32to5;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_v;
    logic        load;
    logic        e;
    logic        ack;
    logic [4:0]  out_v;
    logic        valid;
    logic [5:0]  count;
    logic        overrun;
    logic        state;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        string      tag;
        logic [4:0] out;
        logic       valid;
        logic [5:0] cnt;
        logic       ovr;
        logic       st;
    } exp_t;

    exp_t q[$];

    pending_encoder_32to5 dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_in      (in_v),
        .i_load    (load),
        .i_e       (e),
        .i_ack     (ack),
        .o_out     (out_v),
        .o_valid   (valid),
        .o_count   (count),
        .o_overrun (overrun),
        .o_state   (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input string fld,
                       input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, got, want);
        end
    endtask

    task automatic push(input string tag, input logic [4:0] o,
                        input logic v, input logic [5:0] c,
                        input logic ov, input logic st);
        exp_t x;
        x.tag = tag; x.out = o; x.valid = v;
        x.cnt = c; x.ovr = ov; x.st = st;
        q.push_back(x);
    endtask

    task automatic pop_check();
        exp_t x;
        if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $error("FAIL scoreboard observed=empty expected=entry");
        end else begin
            x = q.pop_front();
            chk(x.tag, "out", 32'(out_v), 32'(x.out));
            chk(x.tag, "valid", 32'(valid), 32'(x.valid));
            chk(x.tag, "count", 32'(count), 32'(x.cnt));
            chk(x.tag, "overrun", 32'(overrun), 32'(x.ovr));
            chk(x.tag, "state", 32'(state), 32'(x.st));
        end
    endtask

    // Drive one cycle of stimulus, queue its expected outcome, clock it.
    task automatic step(input logic r, input logic ld, input logic [31:0] d,
                        input logic en, input logic a, input string tag,
                        input logic [4:0] o, input logic v, input logic [5:0] c,
                        input logic ov, input logic st);
        rst = r; load = ld; in_v = d; e = en; ack = a;
        push(tag, o, v, c, ov, st);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; in_v = '0; e = 1'b0; ack = 1'b0;
        @(negedge clk);

        step(1, 0, 32'h0, 0, 0, "rst0", 0, 0, 0, 0, 0);
        step(1, 1, 32'hFF, 1, 1, "rst1", 0, 0, 0, 0, 0);

        // basic two-bit serialisation
        step(0, 1, 32'h0000_0202, 1, 0, "ld202", 1, 1, 2, 0, 1);
        step(0, 0, 32'h0, 1, 1, "ack1", 9, 1, 1, 0, 1);
        step(0, 0, 32'h0, 1, 1, "ack9", 0, 0, 0, 0, 0);
        step(0, 0, 32'h0, 1, 1, "ackidle", 0, 0, 0, 0, 0);

        // enable gating
        step(0, 1, 32'h8000_0000, 0, 0, "e0ld", 0, 0, 1, 0, 1);
        step(0, 0, 32'h0, 0, 1, "e0ack", 0, 0, 1, 0, 1);
        ack = 1'b0;
        e = 1'b1;
        push("e1comb", 31, 1, 1, 0, 1);
        #1;
        pop_check();
        step(0, 0, 32'h0, 1, 1, "ack31", 0, 0, 0, 0, 0);

        // all 32 bits, drained one per cycle
        step(0, 1, 32'hFFFF_FFFF, 1, 0, "ldall", 0, 1, 32, 0, 1);
        for (int k = 0; k < 32; k++) begin
            if (k < 31) begin
                step(0, 0, 32'h0, 1, 1, $sformatf("drain%0d", k),
                     5'(k + 1), 1, 6'(31 - k), 0, 1);
            end else begin
                step(0, 0, 32'h0, 1, 1, "drain31", 0, 0, 0, 0, 0);
            end
        end

        // load and handshake on the same bit, then overrun
        step(0, 1, 32'h10, 1, 0, "ld10", 4, 1, 1, 0, 1);
        step(0, 1, 32'h10, 1, 1, "ldhs10", 4, 1, 1, 0, 1);
        step(0, 1, 32'h10, 1, 0, "ovr10", 4, 1, 1, 1, 1);
        step(0, 0, 32'h0, 1, 1, "ovrack", 0, 0, 0, 1, 0);
        step(0, 0, 32'h0, 1, 1, "ovrhold", 0, 0, 0, 1, 0);

        // zero load, then reset overriding load/ack
        step(0, 1, 32'hF0, 1, 0, "ldF0", 4, 1, 4, 1, 1);
        step(0, 1, 32'h0, 1, 0, "ldzero", 4, 1, 4, 1, 1);
        step(1, 1, 32'h1, 1, 1, "rstld", 0, 0, 0, 0, 0);
        step(0, 1, 32'h1, 1, 0, "postrst", 0, 1, 1, 0, 1);
        step(0, 0, 32'h0, 1, 1, "postack", 0, 0, 0, 0, 0);

        // ack with valid low on the load edge is ignored
        step(0, 1, 32'h4, 1, 1, "ackinv", 2, 1, 1, 0, 1);
        step(0, 0, 32'h0, 1, 1, "ack2", 0, 0, 0, 0, 0);

        // priority across the word
        step(0, 1, 32'h8000_0100, 1, 0, "ldpri", 8, 1, 2, 0, 1);
        step(0, 0, 32'h0, 1, 1, "pri8", 31, 1, 1, 0, 1);
        step(0, 0, 32'h0, 1, 1, "pri31", 0, 0, 0, 0, 0);

        n_chk++;
        assert (q.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_left observed=%0d expected=0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
